// File: rtl/computer_top.sv
// Minisys I/O demonstrator top: switch conditioning, enter debounce and the interactive case FSM.
// Optional power-on LED sweep is compiled in with `define STARTUP_ANIM_EN.
module computer_top #(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned STARTUP_CYCLES  = 1024
) (
  input  logic [23:0] Minisys_Switches,
  output logic [23:0] Minisys_Lights,
  input  logic        Minisys_Clock,
  input  logic [4:0]  Minisys_Button
);

  localparam int unsigned CntW        = $clog2(DEBOUNCE_CYCLES + 1);
  // Long enough for the sync chain, the debouncer and the edge detector to settle after reset.
  localparam int unsigned SettleCycles = SYNC_STAGES + DEBOUNCE_CYCLES + 4;
  localparam int unsigned SettleW      = $clog2(SettleCycles + 1);

  typedef enum logic [2:0] {StIdle, StEcho, StArmed, StResult, StStartup} state_e;

  logic        rst;
  logic [23:0] sync_q [SYNC_STAGES];
  logic [23:0] sw_s;
  logic        deb_q, deb_d1_q;
  logic [CntW-1:0]    deb_cnt_q;
  logic [SettleW-1:0] settle_q;
  logic        settled, rise, fall;
  state_e      state_q;
  logic [2:0]  case_q;
  logic [15:0] op_q, result_q;
  logic [23:0] lights_q;
  logic        unused_inputs;

  assign rst           = Minisys_Button[3];
  assign sw_s          = sync_q[SYNC_STAGES-1];
  assign unused_inputs = ^{Minisys_Button[4], Minisys_Button[2:0], sw_s[19:16]};

  always_ff @(posedge Minisys_Clock) begin
    if (rst) begin
      for (int i = 0; i < int'(SYNC_STAGES); i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= Minisys_Switches;
      for (int i = 1; i < int'(SYNC_STAGES); i++) sync_q[i] <= sync_q[i-1];
    end
  end

  always_ff @(posedge Minisys_Clock) begin
    if (rst) begin
      deb_q     <= 1'b0;
      deb_d1_q  <= 1'b0;
      deb_cnt_q <= '0;
      settle_q  <= '0;
    end else begin
      deb_d1_q <= deb_q;
      if (!settled) settle_q <= settle_q + SettleW'(1);
      if (sw_s[20] != deb_q) begin
        if (deb_cnt_q == CntW'(DEBOUNCE_CYCLES - 1)) begin
          deb_q     <= sw_s[20];
          deb_cnt_q <= '0;
        end else begin
          deb_cnt_q <= deb_cnt_q + CntW'(1);
        end
      end else begin
        deb_cnt_q <= '0;
      end
    end
  end

  // Edges are masked until settled so an enter switch held high through reset needs a fresh
  // fall and rise before anything is captured.
  assign settled = (settle_q == SettleW'(SettleCycles));
  assign rise    = settled & deb_q & ~deb_d1_q;
  assign fall    = settled & ~deb_q & deb_d1_q;

  function automatic logic [15:0] calc(input logic [2:0] sel, input logic [15:0] op);
    logic [15:0] r;
    logic [4:0]  clz;
    logic [7:0]  rev;
    logic        pal;
    clz = 5'd16;
    pal = 1'b1;
    for (int i = 0; i < 16; i++) if (op[i]) clz = 5'(15 - i);
    for (int i = 0; i < 8; i++) begin
      rev[i] = op[7-i];
      if (op[i] != op[15-i]) pal = 1'b0;
    end
    case (sel)
      3'd0:    r = {15'b0, (op != 16'd0) && ((op & (op - 16'd1)) == 16'd0)};
      3'd1:    r = {15'b0, ^op};
      3'd2:    r = {11'b0, clz};
      3'd3:    r = {8'b0, rev};
      3'd4:    r = {7'b0, {1'b0, op[7:0]} + {1'b0, op[15:8]}};
      3'd5:    r = {8'b0, op[7:0]} - {8'b0, op[15:8]};
      3'd6:    r = 16'(op[7:0]) * 16'(op[15:8]);
      default: r = {15'b0, pal};
    endcase
    return r;
  endfunction

`ifdef STARTUP_ANIM_EN
  localparam int unsigned StepCycles = (STARTUP_CYCLES / 32 > 0) ? STARTUP_CYCLES / 32 : 1;
  localparam int unsigned StW        = $clog2(STARTUP_CYCLES + 1);
  logic [StW-1:0] startup_cnt_q;
  logic [23:0]    marker;
  assign marker = 24'd1 << (startup_cnt_q / StW'(StepCycles));
`else
  logic [31:0] unused_startup;
  assign unused_startup = STARTUP_CYCLES;
`endif

  // LED image is loaded alongside each state change so the display tracks state_q exactly.
  always_ff @(posedge Minisys_Clock) begin
    if (rst) begin
`ifdef STARTUP_ANIM_EN
      state_q       <= StStartup;
      startup_cnt_q <= '0;
`else
      state_q       <= StIdle;
`endif
      case_q   <= '0;
      op_q     <= '0;
      result_q <= '0;
      lights_q <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (rise) begin
            case_q   <= sw_s[23:21];
            op_q     <= sw_s[15:0];
            lights_q <= {1'b0, sw_s[23:21], 4'b0, sw_s[15:0]};
            state_q  <= StEcho;
          end else begin
            lights_q <= 24'h800000;
          end
        end
        StEcho: begin
          if (fall) begin
            lights_q <= {1'b1, case_q, 4'b0, op_q};
            state_q  <= StArmed;
          end else begin
            lights_q <= {1'b0, case_q, 4'b0, op_q};
          end
        end
        StArmed: begin
          if (rise) begin
            result_q <= calc(case_q, op_q);
            lights_q <= {1'b0, case_q, 3'b0, 1'b1, calc(case_q, op_q)};
            state_q  <= StResult;
          end else begin
            lights_q <= {1'b1, case_q, 4'b0, op_q};
          end
        end
        StResult: begin
          if (fall) begin
            lights_q <= 24'h800000;
            state_q  <= StIdle;
          end else begin
            lights_q <= {1'b0, case_q, 3'b0, 1'b1, result_q};
          end
        end
`ifdef STARTUP_ANIM_EN
        StStartup: begin
          if (startup_cnt_q == StW'(STARTUP_CYCLES - 1)) begin
            lights_q <= 24'h800000;
            state_q  <= StIdle;
          end else begin
            startup_cnt_q <= startup_cnt_q + StW'(1);
            lights_q      <= marker;
          end
        end
`endif
        default: begin
          lights_q <= 24'h800000;
          state_q  <= StIdle;
        end
      endcase
    end
  end

  assign Minisys_Lights = lights_q;

endmodule

// File: tb/tb_computer_top.sv
// Directed bench for computer_top: reset, every case function, debounce glitch, reset abort,
// and enter held through reset.
module tb_computer_top;

  logic        clk = 1'b0;
  logic [4:0]  btn;
  logic [23:0] sw;
  logic [23:0] lights;
  int          total = 0;
  int          bad   = 0;

  always #5 clk = ~clk;

  computer_top dut (
    .Minisys_Switches(sw),
    .Minisys_Lights  (lights),
    .Minisys_Clock   (clk),
    .Minisys_Button  (btn)
  );

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [23:0] exp);
    total++;
    assert (lights === exp) else begin
      bad++;
      $error("FAIL %s lights=%h expected=%h", tag, lights, exp);
    end
  endtask

  task automatic set_enter(input logic v);
    sw[20] = v;
    tick(30);
  endtask

  task automatic run_case(input string tag, input logic [2:0] c, input logic [15:0] op,
                          input logic [15:0] res);
    sw = {c, 1'b0, 4'b0, op};
    tick(5);
    set_enter(1'b1);
    check({tag, "/echo"}, {1'b0, c, 4'b0, op});
    // Latched values must not follow the switches any more.
    sw[23:21] = ~c;
    sw[15:0]  = ~op;
    set_enter(1'b0);
    check({tag, "/armed"}, {1'b1, c, 4'b0, op});
    set_enter(1'b1);
    check({tag, "/result"}, {1'b0, c, 3'b0, 1'b1, res});
    set_enter(1'b0);
    check({tag, "/idle"}, 24'h800000);
  endtask

  initial begin
    sw  = 24'h0;
    btn = 5'b01000;
    tick(2);
    check("reset_lights", 24'h0);
    tick(23);
    btn = 5'b00000;
    tick(1124);
    check("idle_after_reset", 24'h800000);

    run_case("c0_a1",   3'd0, 16'h0001, 16'h0001);
    run_case("c0_a6",   3'd0, 16'h0006, 16'h0000);
    run_case("c0_a0",   3'd0, 16'h0000, 16'h0000);
    run_case("c1_odd",  3'd1, 16'h0007, 16'h0001);
    run_case("c2_zero", 3'd2, 16'h0000, 16'h0010);
    run_case("c2_bit8", 3'd2, 16'h0100, 16'h0007);
    run_case("c3_rev",  3'd3, 16'h00B1, 16'h008D);
    run_case("c4_sum",  3'd4, 16'hFFFF, 16'h01FE);
    run_case("c5_sub",  3'd5, 16'h0201, 16'hFFFF);
    run_case("c6_mul",  3'd6, 16'h0304, 16'h000C);
    run_case("c7_pal",  3'd7, 16'h8001, 16'h0001);
    run_case("c7_npal", 3'd7, 16'h8000, 16'h0000);

    // Enter glitch shorter than the debounce window.
    sw = 24'h000042;
    tick(5);
    sw[20] = 1'b1;
    tick(8);
    sw[20] = 1'b0;
    tick(30);
    check("glitch_ignored", 24'h800000);

    // Reset while ARMED aborts the case.
    sw = {3'd6, 1'b0, 4'b0, 16'h0304};
    tick(5);
    set_enter(1'b1);
    set_enter(1'b0);
    check("abort/armed", {1'b1, 3'd6, 4'b0, 16'h0304});
    btn = 5'b01000;
    tick(3);
    check("abort/reset", 24'h0);
    btn = 5'b00000;
    tick(1124);
    check("abort/idle", 24'h800000);

    // Enter held high through reset: no capture until a clean fall and rise.
    sw  = {3'd0, 1'b1, 4'b0, 16'h0010};
    btn = 5'b01000;
    tick(25);
    btn = 5'b00000;
    tick(1124);
    check("held/no_capture", 24'h800000);
    set_enter(1'b0);
    check("held/after_fall", 24'h800000);
    set_enter(1'b1);
    check("held/echo", {1'b0, 3'd0, 4'b0, 16'h0010});
    set_enter(1'b0);
    set_enter(1'b1);
    check("held/result", {1'b0, 3'd0, 3'b0, 1'b1, 16'h0001});
    set_enter(1'b0);
    check("held/idle", 24'h800000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
